// File: rtl/pgr_rsp_formatter_32bit_if.sv
// pgr_rsp_formatter_32bit_if: response handshake, TX FIFO write port and raw UART passthrough bundle.
interface pgr_rsp_formatter_32bit_if #(
  parameter int DW = 32
);
  logic          apb_en;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_is_read;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_drop;
  logic          tx_fifo_full;
  logic          tx_fifo_wr;
  logic [7:0]    tx_fifo_wdata;
  logic          uart_txvld;
  logic [7:0]    uart_txdata;
  logic          uart_txfull;
  modport master (
    output apb_en, rsp_valid, rsp_is_read, rsp_rdata, tx_fifo_full, uart_txvld, uart_txdata,
    input  rsp_ready, rsp_drop, tx_fifo_wr, tx_fifo_wdata, uart_txfull
  );
  modport slave (
    input  apb_en, rsp_valid, rsp_is_read, rsp_rdata, tx_fifo_full, uart_txvld, uart_txdata,
    output rsp_ready, rsp_drop, tx_fifo_wr, tx_fifo_wdata, uart_txfull
  );
endinterface

// File: rtl/pgr_rsp_formatter_32bit.sv
// pgr_rsp_formatter_32bit: serialises one bus response (header, data LSB byte first) into the UART TX FIFO.
// Define RSP_CHKSUM_EN to append a mod-256 sum byte of header and data to every frame.
module pgr_rsp_formatter_32bit #(
  parameter int         DW       = 32,
  parameter bit         WR_ACK   = 1'b1,
  parameter logic [7:0] HDR_R    = 8'h72,
  parameter logic [7:0] HDR_W    = 8'h77,
  parameter int         CLK_FREQ = 50
) (
  input logic clk,
  input logic rst_n,
  pgr_rsp_formatter_32bit_if.slave bus
);
  localparam int NB  = DW / 8;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO = 100 * CLK_FREQ;
  localparam int TW  = $clog2(TMO + 1);
`ifdef RSP_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_e;
  state_e        state_q;
  logic          init_q;
  logic          is_read_q;
  logic          drop_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    chk_byte;
  logic [7:0]    tx_byte;
  logic          byte_st;
  logic          fmt_wr;
  logic          stall;
  logic          accept;
  assign byte_st = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
  assign fmt_wr  = bus.apb_en && byte_st && !bus.tx_fifo_full;
  assign stall   = bus.apb_en && byte_st && bus.tx_fifo_full;
  assign accept  = bus.rsp_valid && bus.rsp_ready;
  assign tx_byte = (state_q == HDR)  ? (is_read_q ? HDR_R : HDR_W) :
                   (state_q == DATA) ? rdata_q[7:0] : chk_byte;
  assign bus.rsp_ready     = init_q && bus.apb_en && (state_q == IDLE);
  assign bus.rsp_drop      = drop_q;
  assign bus.tx_fifo_wr    = bus.apb_en ? fmt_wr : bus.uart_txvld;
  assign bus.tx_fifo_wdata = bus.apb_en ? tx_byte : bus.uart_txdata;
  assign bus.uart_txfull   = bus.apb_en ? 1'b1 : bus.tx_fifo_full;
`ifdef RSP_CHKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (fmt_wr && state_q != CHK) sum_q <= sum_q + tx_byte;
  assign chk_byte = sum_q;
`else
  assign chk_byte = 8'h00;
`endif
  // Data leaves from the bottom byte of rdata_q, shifted down after each data write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      is_read_q <= 1'b0;
      drop_q    <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
    end else begin
      init_q <= 1'b1;
      drop_q <= 1'b0;
      if (bus.apb_en) begin
        tmo_q <= stall ? tmo_q + TW'(1) : '0;
        case (state_q)
          IDLE: if (accept) begin
            rdata_q   <= bus.rsp_rdata;
            is_read_q <= bus.rsp_is_read;
            cnt_q     <= '0;
            state_q   <= (bus.rsp_is_read || WR_ACK) ? HDR : DONE;
          end
          HDR:  if (fmt_wr) state_q <= is_read_q ? DATA : (CHK_EN ? CHK : DONE);
          DATA: if (fmt_wr) begin
            rdata_q <= rdata_q >> 8;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(NB - 1)) state_q <= CHK_EN ? CHK : DONE;
          end
          CHK:  if (fmt_wr) state_q <= DONE;
          default: state_q <= IDLE;
        endcase
        // Abandon the frame once the FIFO has been full for the whole timeout window.
        if (stall && tmo_q == TW'(TMO - 1)) begin
          drop_q  <= 1'b1;
          state_q <= IDLE;
          tmo_q   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pgr_rsp_formatter_32bit.sv
// tb_pgr_rsp_formatter_32bit: directed checks of framing, stalls, timeout, passthrough and reset.
module tb_pgr_rsp_formatter_32bit;
`ifdef RSP_CHKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int TMO = 100 * 50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int drops = 0;
  int viol = 0;
  int w0 = 0;
  logic [7:0] log_q[$];
  int cyc_q[$];
  always #5 clk = ~clk;
  pgr_rsp_formatter_32bit_if #(.DW(32)) b();
  pgr_rsp_formatter_32bit_if #(.DW(32)) b0();
  pgr_rsp_formatter_32bit #(.DW(32), .WR_ACK(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  pgr_rsp_formatter_32bit #(.DW(32), .WR_ACK(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (b.tx_fifo_wr) begin
      log_q.push_back(b.tx_fifo_wdata);
      cyc_q.push_back(cyc);
    end
    if (b.rsp_drop) drops <= drops + 1;
    if (b.apb_en && b.tx_fifo_wr && b.tx_fifo_full) viol <= viol + 1;
    if (b0.tx_fifo_wr) w0 <= w0 + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc_w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic rd, input logic [31:0] d);
    b.rsp_valid = 1'b1;
    b.rsp_is_read = rd;
    b.rsp_rdata = d;
    cyc_w(1);
    b.rsp_valid = 1'b0;
    b.rsp_rdata = ~d;
  endtask
  task automatic chk_log(input string tag, input int base, input int n, input logic [47:0] exp);
    chk({tag, "_len"}, 32'(log_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk(tag, (base + i < log_q.size()) ? {24'h0, log_q[base + i]} : 32'hFFFF_FFFF, {24'h0, exp[8*i +: 8]});
  endtask
  initial begin
    int base;
    int k;
    int d0;
    b.apb_en = 1'b1; b.rsp_valid = 1'b0; b.rsp_is_read = 1'b0; b.rsp_rdata = '0;
    b.tx_fifo_full = 1'b0; b.uart_txvld = 1'b0; b.uart_txdata = '0;
    b0.apb_en = 1'b1; b0.rsp_valid = 1'b0; b0.rsp_is_read = 1'b0; b0.rsp_rdata = '0;
    b0.tx_fifo_full = 1'b0; b0.uart_txvld = 1'b0; b0.uart_txdata = '0;
    #1;
    chk("rst_ready", b.rsp_ready, 0);
    chk("rst_wr", b.tx_fifo_wr, 0);
    chk("rst_drop", b.rsp_drop, 0);
    chk("rst_txfull", b.uart_txfull, 1);
    cyc_w(3);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", b.rsp_ready, 0);
    cyc_w(1);
    chk("ready_post_rst", b.rsp_ready, 1);
    base = log_q.size();
    frame(1'b1, 32'h1234_5678);
    chk("rd_hdr_wr", b.tx_fifo_wr, 1);
    chk("rd_hdr_byte", b.tx_fifo_wdata, 8'h72);
    chk("rd_busy_ready", b.rsp_ready, 0);
    cyc_w(4);
    chk("rd_last_byte", b.tx_fifo_wdata, 8'h12);
    cyc_w(1 + CK);
    chk("rd_done_wr", b.tx_fifo_wr, 0);
    chk("rd_done_ready", b.rsp_ready, 0);
    cyc_w(1);
    chk("rd_idle_ready", b.rsp_ready, 1);
    chk_log("rd_frame", base, 5 + CK, 48'h86_12_34_56_78_72);
    for (int i = 1; i < 5 + CK; i++) chk("rd_consec", 32'(cyc_q[base + i] - cyc_q[base]), 32'(i));
    base = log_q.size();
    frame(1'b0, 32'hDEAD_BEEF);
    chk("wr_hdr_byte", b.tx_fifo_wdata, 8'h77);
    cyc_w(3 + CK);
    chk("wr_ready", b.rsp_ready, 1);
    chk_log("wr_frame", base, 1 + CK, 48'h77_77);
    d0 = w0;
    b0.rsp_valid = 1'b1;
    b0.rsp_is_read = 1'b0;
    cyc_w(1);
    b0.rsp_valid = 1'b0;
    chk("noack_busy", b0.rsp_ready, 0);
    cyc_w(1);
    chk("noack_ready", b0.rsp_ready, 1);
    chk("noack_writes", 32'(w0 - d0), 0);
    base = log_q.size();
    frame(1'b1, 32'h1234_5678);
    cyc_w(1);
    b.tx_fifo_full = 1'b1;
    #1;
    chk("full_no_wr", b.tx_fifo_wr, 0);
    cyc_w(3);
    b.tx_fifo_full = 1'b0;
    cyc_w(6);
    chk_log("stall_frame", base, 5 + CK, 48'h86_12_34_56_78_72);
    chk("stall_gap", 32'(cyc_q[base + 1] - cyc_q[base]), 4);
    chk("stall_tail", 32'(cyc_q[base + 4] - cyc_q[base + 1]), 3);
    base = log_q.size();
    d0 = drops;
    frame(1'b1, 32'hCAFE_BABE);
    cyc_w(1);
    b.tx_fifo_full = 1'b1;
    k = 1;
    #1;
    while (!b.rsp_drop && k < TMO + 20) begin
      cyc_w(1);
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'(TMO + 1));
    chk("tmo_ready", b.rsp_ready, 1);
    cyc_w(1);
    chk("tmo_pulse", b.rsp_drop, 0);
    b.tx_fifo_full = 1'b0;
    cyc_w(4);
    chk("tmo_drops", 32'(drops - d0), 1);
    chk_log("tmo_partial", base, 1, 48'h72);
    base = log_q.size();
    frame(1'b1, 32'h0102_0304);
    cyc_w(6);
    chk_log("post_tmo_frame", base, 5 + CK, 48'h7C_01_02_03_04_72);
    b.apb_en = 1'b0;
    b.uart_txvld = 1'b1;
    b.uart_txdata = 8'hA5;
    b.rsp_valid = 1'b1;
    b.rsp_is_read = 1'b1;
    b.tx_fifo_full = 1'b1;
    #1;
    chk("raw_wr", b.tx_fifo_wr, 1);
    chk("raw_data", b.tx_fifo_wdata, 8'hA5);
    chk("raw_ready", b.rsp_ready, 0);
    chk("raw_full1", b.uart_txfull, 1);
    b.tx_fifo_full = 1'b0;
    #1;
    chk("raw_full0", b.uart_txfull, 0);
    cyc_w(2);
    b.rsp_valid = 1'b0;
    b.apb_en = 1'b1;
    #1;
    chk("own_txfull", b.uart_txfull, 1);
    chk("own_ignore_raw", b.tx_fifo_wr, 0);
    chk("own_ready", b.rsp_ready, 1);
    b.uart_txvld = 1'b0;
    base = log_q.size();
    frame(1'b1, 32'hA1B2_C3D4);
    cyc_w(1);
    b.apb_en = 1'b0;
    #1;
    chk("toggle_no_wr", b.tx_fifo_wr, 0);
    cyc_w(3);
    b.apb_en = 1'b1;
    cyc_w(6);
    chk_log("toggle_frame", base, 5 + CK, 48'h5C_A1_B2_C3_D4_72);
    frame(1'b1, 32'h5555_AAAA);
    cyc_w(1);
    rst_n = 1'b0;
    #1;
    base = log_q.size();
    chk("rst_mid_wr", b.tx_fifo_wr, 0);
    chk("rst_mid_ready", b.rsp_ready, 0);
    cyc_w(3);
    rst_n = 1'b1;
    cyc_w(1);
    chk("rst_mid_idle", b.rsp_ready, 1);
    cyc_w(3);
    chk("rst_mid_bytes", 32'(log_q.size() - base), 0);
    chk("never_wr_full", 32'(viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
